// File: rtl/x_feeder.sv
// x_feeder: input-side operand buffer for the 4-lane mul-accumulate ALU.
//
// Takes the input matrix as a byte stream (in_data/in_valid/in_ready) and packs
// each group of 4 bytes into one step entry. Entries are queued in a DEPTH-entry
// FIFO. The head entry is shown on X_reg1..X_reg4, and each X_shift pulse pops it.
// The block also counts pops modulo STEPS (step_cnt), pulses matrix_end after
// the last step of a matrix, and raises a sticky underflow flag when X_shift
// arrives while the FIFO is empty.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_data/in_valid    byte stream input
//   in_ready            beat accepted when in_valid && in_ready
//   X_shift             pop one step per asserted cycle
//   X_reg1..X_reg4      head lanes 0..3, zero-extended to 9 bits (0 when empty)
//   x_avail, full       FIFO not empty / FIFO holds DEPTH entries
//   level               FIFO entry count
//   step_cnt            successful pops modulo STEPS
//   matrix_end          one-cycle pulse after the pop of step STEPS-1
//   underflow           sticky; cleared only by rst
module x_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned STEPS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     X_shift,
  output logic [8:0]               X_reg1,
  output logic [8:0]               X_reg2,
  output logic [8:0]               X_reg3,
  output logic [8:0]               X_reg4,
  output logic                     x_avail,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [4:0]               step_cnt,
  output logic                     matrix_end,
  output logic                     underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [1:0]      lane_q, lane_d;
  logic [23:0]     stage_q, stage_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;
  logic [4:0]      step_q, step_d;
  logic            matrix_end_q, matrix_end_d;
  logic            underflow_q, underflow_d;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     head;

  logic            accept;
  logic            push;
  logic            pop;

  assign full     = (level_q == (PtrW+1)'(DEPTH));
  assign x_avail  = (level_q != '0);
  // Only the completing byte can be stalled; bytes 0..2 go to staging.
  assign in_ready = (lane_q != 2'd3) || !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (lane_q == 2'd3);
  assign pop      = X_shift && x_avail;

  always_comb begin
    lane_d       = lane_q;
    stage_d      = stage_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    step_d       = step_q;
    matrix_end_d = 1'b0;
    underflow_d  = underflow_q;

    if (accept) begin
      lane_d = lane_q + 2'd1;
      unique case (lane_q)
        2'd0:    stage_d[7:0]   = in_data;
        2'd1:    stage_d[15:8]  = in_data;
        2'd2:    stage_d[23:16] = in_data;
        default: ;
      endcase
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (step_q == 5'(STEPS - 1)) begin
        step_d       = '0;
        matrix_end_d = 1'b1;
      end else begin
        step_d = step_q + 5'd1;
      end
    end else if (X_shift) begin
      underflow_d = 1'b1;
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= '0;
      stage_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      step_q       <= '0;
      matrix_end_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      stage_q      <= stage_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      step_q       <= step_d;
      matrix_end_q <= matrix_end_d;
      underflow_q  <= underflow_d;
    end
  end

  // Entry storage carries no reset; contents are qualified by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_data, stage_q};
    end
  end

  assign head   = x_avail ? mem_q[rd_ptr_q] : 32'd0;
  assign X_reg1 = {1'b0, head[7:0]};
  assign X_reg2 = {1'b0, head[15:8]};
  assign X_reg3 = {1'b0, head[23:16]};
  assign X_reg4 = {1'b0, head[31:24]};

  assign level      = level_q;
  assign step_cnt   = step_q;
  assign matrix_end = matrix_end_q;
  assign underflow  = underflow_q;

endmodule

// File: doc/x_feeder.md
# x_feeder

Input-side operand buffer for the 4-lane mul-accumulate ALU. It accepts the input matrix as a byte stream with valid/ready, packs every 4 consecutive bytes into one step entry, and queues those entries in a FIFO. The head entry is presented on `X_reg1..X_reg4`, and the FIFO pops on each `X_shift` pulse the ALU issues. It also tracks the 32-step matrix boundary and flags underflow.

## Interface
- `DEPTH`, 8: FIFO entries (steps); power of two, at least 2.
- `STEPS`, 32: ALU steps per matrix. This matches the ALU's 5-bit step counter.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in 8: unsigned input element.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: the block accepts a beat when `in_valid && in_ready`.
- `X_shift` in 1: pop the head entry, one step per asserted cycle.
- `X_reg1`, `X_reg2`, `X_reg3`, `X_reg4` out 9 each: head entry lanes 0..3, zero-extended.
- `x_avail` out 1: FIFO not empty.
- `full` out 1: FIFO holds `DEPTH` entries.
- `level` out clog2(`DEPTH`)+1: FIFO entry count.
- `step_cnt` out 5: successful pops modulo `STEPS`.
- `matrix_end` out 1: one-cycle pulse after the pop of step `STEPS`-1.
- `underflow` out 1: sticky error flag.

## Operation
- **Lane assembly**
  - A 2-bit `lane` counter and a 24-bit staging register collect bytes.
  - Accepted beats with `lane` = 0, 1, 2 are written into staging lanes 0, 1, 2, and `lane` increments.
  - The accepted beat with `lane` = 3 pushes {byte3, staging2, staging1, staging0} into the FIFO tail, and `lane` returns to 0.
- **Input flow control**
  - `in_ready` = (`lane` != 3) || !`full`.
  - Bytes 0–2 are never stalled. Only byte 3 waits while the FIFO is full.
- **FIFO**
  - Read and write pointers are clog2(`DEPTH`) bits wide and wrap naturally.
  - `level` increments on a push alone, decrements on a pop alone, and is unchanged when a push and a pop happen in the same cycle.
- **Pop**
  - A pop happens when `X_shift` && `x_avail`.
  - On a pop, the read pointer advances and `step_cnt` increments, wrapping from `STEPS`-1 to 0.
  - `matrix_end` is registered high for one cycle when the pop takes `step_cnt` from `STEPS`-1 to 0.
- **Underflow**
  - `X_shift` while empty leaves the pointers, `level` and `step_cnt` unchanged and sets `underflow`.
  - `underflow` is cleared only by `rst`.
- **Outputs**
  - `X_reg1..4` = {1'b0, head lane n} when `x_avail`, and 0 when empty.
  - They are driven combinationally from registered storage through the read pointer; no data path is combinational from `in_data`.
- **Simultaneous push and pop when full**
  - The push is blocked because `in_ready` = 0 for byte 3.
  - The pop proceeds.
  - Byte 3 is accepted on the next cycle.
- **Reset**
  - `rst` clears `lane`, the pointers, `level`, `step_cnt`, `matrix_end` and `underflow`.
  - A partially assembled step is discarded.
  - Storage contents are don't-care.

## Timing
- **Reset values**
  - `in_ready` = 1, `x_avail` = 0, `full` = 0, `level` = 0.
  - `X_reg1..4` = 0.
  - `step_cnt` = 0, `matrix_end` = 0, `underflow` = 0.
- **Write-to-read latency**
  - After the edge that accepts byte 3, the entry is visible on `X_reg1..4` and `x_avail` = 1 in the next cycle, provided the FIFO was empty.
- **Pop-to-data latency**
  - With `X_shift` high at edge t, the next entry is on `X_reg1..4` after edge t.
  - The ALU samples lane values in the same cycle it asserts `X_shift`.
  - Back-to-back `X_shift` pops one entry per cycle.
- **Throughput**
  - Sustained input is 4 beats per step.
  - The controller must hold off `ALU_en` until `level` covers the steps it intends to run. The block does not throttle the ALU.
- **Flag timing**
  - `full`, `x_avail` and `level` reflect register state only; they update on the edge after the push or pop.

## Test plan
- **Single step**
  - Stimulus: after reset, send 0x01, 0x02, 0x03, 0xFF.
  - Required response: next cycle `X_reg1..4` = 1, 2, 3, 255, `level` = 1, `x_avail` = 1.
  - Then assert `X_shift` for one cycle → `level` = 0, `X_reg` = 0, `step_cnt` = 1.
- **Fill to full**
  - Stimulus: send 8 steps with no pops, then 3 bytes of step 9.
  - Required response: `full` = 1; `in_ready` stays 1 through the 3 bytes and drops to 0 at `lane` = 3.
  - Then one `X_shift` → `in_ready` returns to 1 the next cycle, byte 3 is accepted, and `level` returns to 8.
- **Matrix boundary**
  - Stimulus: stream 32 steps while popping continuously.
  - Required response: `matrix_end` pulses exactly once, for one cycle, after pop 32; `step_cnt` wraps to 0.
  - Entries come out in FIFO order, and the pointers wrap at least 4 times.
- **Concurrent push and pop**
  - Stimulus: with `level` = 3, complete a push in the same cycle as an `X_shift`.
  - Required response: `level` stays 3 and the head advances to the old second entry.
- **Underflow**
  - Stimulus: assert `X_shift` while empty.
  - Required response: `underflow` = 1 and stays 1; `step_cnt` and `level` are unchanged.
  - A subsequent valid step pops normally.
- **Reset mid-operation**
  - Stimulus: with `level` = 5, `lane` = 2 and `step_cnt` = 17, assert `rst` for one cycle.
  - Required response: all outputs return to their reset values.
  - The next 4 bytes form a complete new step (no leftover lanes).
